flopoco_fmul_stream_adapter: RTL

//   Drives operands into the free-running, fixed-latency FloPoCo multiplier (fmul, no ce, no handshake).

---
 rtl/flopoco_pkg.sv | 20 ++
 rtl/flopoco_sync_fifo.sv | 68 ++++++
 rtl/flopoco_fmul_stream_adapter.sv | 97 +++++++++
 3 files changed

// File: rtl/flopoco_pkg.sv
// Shared FloPoCo word format (exn, sign, exponent, fraction) for the fmul adapter and its benches.
package flopoco_pkg;

   localparam int WE = 4;
   localparam int WF = 4;
   localparam int W  = WE + WF + 3;

   typedef struct packed {
      logic [1:0]    exn;
      logic          sign;
      logic [WE-1:0] exp;
      logic [WF-1:0] frac;
   } fp_t;

   localparam logic [1:0] EXN_ZERO   = 2'b00;
   localparam logic [1:0] EXN_NORMAL = 2'b01;
   localparam logic [1:0] EXN_INF    = 2'b10;
   localparam logic [1:0] EXN_NAN    = 2'b11;

endpackage

// File: rtl/flopoco_sync_fifo.sv
// Synchronous FIFO with registered storage, head read from the read pointer and an occupancy count.
module flopoco_sync_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic          valid_o,
   output logic [CW-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Pops on an empty FIFO are dropped; pushes on a full one cannot happen by credit but are guarded.
   assign do_push = push_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/flopoco_fmul_stream_adapter.sv
// Feeds a free-running fixed-latency FloPoCo fmul and returns its products as a credit-limited valid/ready stream.
module flopoco_fmul_stream_adapter
   import flopoco_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_y,
   output logic [W-1:0] mul_x,
   output logic [W-1:0] mul_y,
   input  logic [W-1:0] mul_r,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic [1:0]   out_exn,
   output logic [15:0]  retired
);

   localparam int FCW = $clog2(DEPTH) + 1;
   localparam int CW  = $clog2(DEPTH + LATENCY + 2) + 1;

   logic [W-1:0]   mul_x_q, mul_x_d;
   logic [W-1:0]   mul_y_q, mul_y_d;
   logic [LATENCY:0] tag_q, tag_d;
   logic [15:0]    retired_q, retired_d;
   logic [FCW-1:0] fifo_count;
   logic [CW-1:0]  used;
   logic           accept, pop, fifo_valid;

   // Credits counted from registered state only: queued results plus products still in the fmul.
   always_comb begin
      used = CW'(fifo_count);
      for (int i = 0; i <= LATENCY; i++) begin
         used = used + CW'(tag_q[i]);
      end
   end

   assign in_ready = (used < CW'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign pop      = fifo_valid && out_ready;

   always_comb begin
      mul_x_d   = mul_x_q;
      mul_y_d   = mul_y_q;
      tag_d     = {tag_q[LATENCY-1:0], accept};
      retired_d = retired_q;
      if (accept) begin
         mul_x_d = in_x;
         mul_y_d = in_y;
      end
      if (pop) begin
         retired_d = retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_x_q   <= '0;
         mul_y_q   <= '0;
         tag_q     <= '0;
         retired_q <= '0;
      end else begin
         mul_x_q   <= mul_x_d;
         mul_y_q   <= mul_y_d;
         tag_q     <= tag_d;
         retired_q <= retired_d;
      end
   end

   // The last tag stage lines up with mul_r holding the product of that issue.
   flopoco_sync_fifo #(
      .W     (W),
      .DEPTH (DEPTH),
      .CW    (FCW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (tag_q[LATENCY]),
      .wdata_i (mul_r),
      .pop_i   (pop),
      .rdata_o (out_r),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign mul_x     = mul_x_q;
   assign mul_y     = mul_y_q;
   assign out_valid = fifo_valid;
   assign out_exn   = out_r[W-1:W-2];
   assign retired   = retired_q;

endmodule
